sopc_run_ctrl: RTL and testbench

SOPC_RUN_CTRL -- requirements
Module: sopc_run_ctrl

---
 rtl/sopc_run_ctrl_pkg.sv | 21 ++
 rtl/sopc_run_ctrl_stall_detect.sv | 59 +++++
 rtl/sopc_run_ctrl.sv | 118 +++++++++++
 tb/tb_sopc_run_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sopc_run_ctrl_pkg.sv
// Shared encodings for the SoPC run controller: FSM states, run status codes
// and the cycle-counter saturation value.
package sopc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } run_state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'b00,
    STAT_PASS    = 2'b01,
    STAT_TIMEOUT = 2'b10,
    STAT_STALL   = 2'b11
  } run_status_e;

  localparam logic [31:0] CYCLE_CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/sopc_run_ctrl_stall_detect.sv
// PC-repeat detector: remembers the last valid PC and counts consecutive
// valid repeats of it, flagging a stall once the repeat count tops out.
module run_stall_detect #(
  parameter int PC_WIDTH    = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                pc_valid_i,
  output logic                stall_o
);

  localparam int             CNT_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STALL_LIMIT - 1);

  logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
  logic                last_vld_q, last_vld_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  // The first valid PC only primes the register; invalid cycles leave everything alone.
  always_comb begin
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    cnt_d      = cnt_q;
    if (clear_i) begin
      last_pc_d  = '0;
      last_vld_d = 1'b0;
      cnt_d      = '0;
    end else if (en_i && pc_valid_i) begin
      if (last_vld_q && (pc_i == last_pc_q)) begin
        if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        last_pc_d  = pc_i;
        last_vld_d = 1'b1;
        cnt_d      = '0;
      end
    end
  end

  assign stall_o = last_vld_q && (cnt_q == CNT_TOP);

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller for a soft core: holds the core in reset after start, then
// watches its fetch PC for a halt address, a stuck PC or a cycle-budget timeout.
module sopc_run_ctrl
  import sopc_run_ctrl_pkg::*;
#(
  parameter int                   RST_HOLD_CYCLES = 10,
  parameter int                   RUN_CYCLES_MAX  = 205,
  parameter int                   PC_WIDTH        = 32,
  parameter int                   STALL_LIMIT     = 8,
  parameter logic [PC_WIDTH-1:0]  HALT_ADDR       = PC_WIDTH'(32'h0000_0100)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                pc_valid_i,
  output logic                soc_rst_o,
  output logic                running_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic [31:0]         cycle_cnt_o
);

  // A zero hold time still spends one cycle in HOLD.
  localparam logic [31:0] HOLD_LAST = (RST_HOLD_CYCLES <= 1) ? 32'd0
                                                             : 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] RUN_MAX   = 32'(RUN_CYCLES_MAX);

  run_state_e  state_q, state_d;
  run_status_e status_q, status_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        soc_rst_q, soc_rst_d;

  logic start_ok;
  logic in_run;
  logic pass_hit;
  logic stall_hit;
  logic timeout_hit;

  assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_run      = (state_q == ST_RUN);
  assign pass_hit    = pc_valid_i && (pc_i == HALT_ADDR);
  assign timeout_hit = (cycle_cnt_q >= RUN_MAX);

  run_stall_detect #(
    .PC_WIDTH    (PC_WIDTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (start_ok),
    .en_i       (in_run),
    .pc_i       (pc_i),
    .pc_valid_i (pc_valid_i),
    .stall_o    (stall_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      status_q    <= STAT_NONE;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      soc_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      soc_rst_q   <= soc_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_HOLD;
      ST_HOLD:          if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
      ST_RUN:           if (pass_hit || stall_hit || timeout_hit) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Status and count are written only on start or during RUN, so DONE freezes them.
  always_comb begin
    status_d    = status_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (start_ok) begin
      status_d    = STAT_NONE;
      hold_cnt_d  = '0;
      cycle_cnt_d = '0;
    end else if (state_q == ST_HOLD) begin
      if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 32'd1;
    end else if (in_run) begin
      if (pass_hit) begin
        status_d = STAT_PASS;
      end else if (stall_hit) begin
        status_d = STAT_STALL;
      end else if (timeout_hit) begin
        status_d = STAT_TIMEOUT;
      end else if (cycle_cnt_q != CYCLE_CNT_SAT) begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
    end
    soc_rst_d = (state_d != ST_RUN);
  end

  always_comb begin
    running_o   = (state_q == ST_RUN);
    done_o      = (state_q == ST_DONE);
    soc_rst_o   = soc_rst_q;
    status_o    = status_q;
    cycle_cnt_o = cycle_cnt_q;
  end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Self-checking bench for sopc_run_ctrl: directed and randomised PC traces are
// scored against a streak-based model of how a run should end.
module tb_sopc_run_ctrl;

  localparam int          HOLD   = 10;
  localparam int          RUNMAX = 205;
  localparam int          STALLN = 8;
  localparam logic [31:0] HALT   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        soc_rst_o;
  logic        running_o;
  logic        done_o;
  logic [1:0]  status_o;
  logic [31:0] cycle_cnt_o;

  int test_count = 0;
  int fail_count = 0;

  logic [31:0] pcs [256];
  bit          vld [256];

  sopc_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_i        (pc_i),
    .pc_valid_i  (pc_valid_i),
    .soc_rst_o   (soc_rst_o),
    .running_o   (running_o),
    .done_o      (done_o),
    .status_o    (status_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // A run ends at the first cycle that shows the halt PC, or that follows a
  // streak of STALLN identical valid PCs, or whose elapsed count hits the budget.
  task automatic modelRun(output int end_k, output int exp_stat);
    int          streak;
    logic [31:0] last;
    bit          have;
    streak = 0; last = '0; have = 0;
    end_k = 255; exp_stat = 0;
    for (int k = 0; k < 256; k++) begin
      if (vld[k] && pcs[k] == HALT) begin end_k = k; exp_stat = 1; return; end
      if (streak >= STALLN)         begin end_k = k; exp_stat = 3; return; end
      if (k >= RUNMAX)              begin end_k = k; exp_stat = 2; return; end
      if (vld[k]) begin
        if (have && pcs[k] == last) streak++;
        else streak = 1;
        last = pcs[k];
        have = 1;
      end
    end
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_flags"}, {29'd0, soc_rst_o, running_o, done_o}, 32'b100);
    checkOutput({tag, "_status"}, {30'd0, status_o}, 32'd0);
    checkOutput({tag, "_cnt"}, cycle_cnt_o, 32'd0);
  endtask

  task automatic applyStimulus(input bit noisy, input int abort_at);
    int end_k, exp_stat;
    modelRun(end_k, exp_stat);
    start = 1'b1; pc_valid_i = 1'b0;
    stepCycle();
    start = 1'b0;
    checkOutput("start_status_clr", {30'd0, status_o}, 32'd0);
    checkOutput("start_cnt_clr", cycle_cnt_o, 32'd0);
    for (int h = 0; h < HOLD; h++) begin
      checkOutput("hold_flags", {29'd0, soc_rst_o, running_o, done_o}, 32'b100);
      pc_i = HALT; pc_valid_i = 1'b1;
      start = noisy && (h == 3);
      stepCycle();
      start = 1'b0;
    end
    pc_valid_i = 1'b0;
    checkOutput("run_entry_flags", {29'd0, soc_rst_o, running_o, done_o}, 32'b010);
    checkOutput("run_entry_cnt", cycle_cnt_o, 32'd0);
    for (int k = 0; k <= end_k; k++) begin
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        checkIdleReset("abort");
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkIdleReset("post_abort");
        return;
      end
      pc_i = pcs[k]; pc_valid_i = vld[k];
      start = noisy && (k % 7 == 3);
      stepCycle();
      start = 1'b0;
      if (k < end_k) begin
        checkOutput("run_busy", {31'd0, running_o}, 32'd1);
        checkOutput("run_cnt", cycle_cnt_o, 32'(k + 1));
      end
    end
    pc_valid_i = 1'b0;
    checkOutput("done_flags", {29'd0, soc_rst_o, running_o, done_o}, 32'b101);
    checkOutput("done_status", {30'd0, status_o}, 32'(exp_stat));
    checkOutput("done_cnt", cycle_cnt_o, 32'(end_k));
    for (int i = 0; i < 3; i++) begin
      pc_i = $urandom; pc_valid_i = 1'b1;
      stepCycle();
    end
    pc_valid_i = 1'b0;
    checkOutput("frozen_status", {30'd0, status_o}, 32'(exp_stat));
    checkOutput("frozen_cnt", cycle_cnt_o, 32'(end_k));
    checkOutput("frozen_done", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) stepCycle();
    checkIdleReset("reset");
    rst = 1'b1;
    repeat (4) stepCycle();
    checkIdleReset("idle_wait");

    // Incrementing PCs that land on the halt address at RUN cycle 50.
    for (int k = 0; k < 256; k++) begin
      pcs[k] = HALT - 32'(4 * (50 - k)); vld[k] = 1'b1;
    end
    applyStimulus(1'b0, -1);

    // Incrementing PCs that never reach the halt address, with noisy starts.
    for (int k = 0; k < 256; k++) begin
      pcs[k] = 32'h2000 + 32'(4 * k); vld[k] = 1'b1;
    end
    applyStimulus(1'b1, -1);

    // Stuck PC with interleaved invalid cycles carrying junk (even the halt PC).
    for (int k = 0; k < 256; k++) begin
      vld[k] = ($urandom_range(0, 2) != 0);
      pcs[k] = vld[k] ? 32'h40 : (($urandom_range(0, 3) == 0) ? HALT : $urandom);
    end
    for (int k = 0; k < 3; k++) vld[k] = 1'b0;
    applyStimulus(1'b0, -1);

    // Halt PC arrives in the same cycle a stall completes and the budget expires.
    for (int k = 0; k < 256; k++) begin
      pcs[k] = 32'h1000 + 32'(4 * k); vld[k] = 1'b1;
    end
    for (int k = 197; k < 205; k++) pcs[k] = 32'h40;
    pcs[205] = HALT;
    applyStimulus(1'b0, -1);

    // Reset pulse in the middle of a run, then a fresh run from scratch.
    for (int k = 0; k < 256; k++) begin
      pcs[k] = 32'h3000 + 32'(4 * k); vld[k] = 1'b1;
    end
    applyStimulus(1'b0, 30);
    for (int k = 0; k < 256; k++) begin
      pcs[k] = HALT - 32'(4 * (40 - k)); vld[k] = 1'b1;
    end
    applyStimulus(1'b1, -1);

    // Random traces over a tiny PC alphabet so streaks, halts and timeouts all occur.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 256; k++) begin
        vld[k] = ($urandom_range(0, 4) != 0);
        pcs[k] = 32'h40 + 32'(4 * $urandom_range(0, (r < 4) ? 1 : 5));
        if ($urandom_range(0, 79) == 0) pcs[k] = HALT;
      end
      applyStimulus(r[0], -1);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
